// File: rtl/mem_arbiter_pkg.sv
// Shared types for the cpu memory arbiter (package mem_pkg).
// Supplies the codebase `WORD width when no other file has defined it.
`ifndef WORD
`define WORD 32
`endif

package mem_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } arb_state_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational two-way picker between fetch and data requests.
// Fixed data priority by default; round-robin on `last` when MEM_ARB_RR_EN is defined.
module arb_pick
  import mem_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
`ifdef MEM_ARB_RR_EN
  input  logic last,
`endif
  output logic grant_if,
  output logic grant_d
);

  always_comb begin
`ifdef MEM_ARB_RR_EN
    // On contention the requester that did not win the previous grant goes first.
    grant_d = d_req && (!if_req || (last == OWNER_IF));
`else
    grant_d = d_req;
`endif
    grant_if = if_req && !grant_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported, fixed-latency memory between cpu fetch and load/store.
// Optional macro MEM_ARB_RR_EN selects round-robin contention instead of data priority.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ADDR_W  = `WORD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic               if_gnt,
  output logic               if_rvalid,
  output logic [`WORD-1:0]   if_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [`WORD-1:0]   d_wdata,
  output logic               d_gnt,
  output logic               d_rvalid,
  output logic [`WORD-1:0]   d_rdata,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [`WORD-1:0]   mem_wdata,
  input  logic [`WORD-1:0]   mem_rdata,
  output logic               busy
);

  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  arb_state_t state;
  logic [2:0] cnt;
  logic       owner;
  logic       rst_q;
  logic       grant_en;
  logic       pick_if;
  logic       pick_d;
  logic       done;
`ifdef MEM_ARB_RR_EN
  logic       last;
`endif

  arb_pick u_pick (
    .if_req   (if_req),
    .d_req    (d_req),
`ifdef MEM_ARB_RR_EN
    .last     (last),
`endif
    .grant_if (pick_if),
    .grant_d  (pick_d)
  );

  // rst_q holds grants off for the cycle after reset, so a request held
  // through reset is only accepted once the cpu side is out of reset too.
  assign grant_en = (state == IDLE) && !rst && !rst_q;
  assign busy     = (state == WAIT);

  always_comb begin
    if_gnt    = grant_en && pick_if;
    d_gnt     = grant_en && pick_d;
    mem_en    = if_gnt || d_gnt;
    mem_we    = d_gnt && d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
    // Response gated by rst so an in-flight access never reports completion.
    done      = (state == WAIT) && (cnt == '0) && !rst;
    if_rvalid = done && (owner == OWNER_IF);
    d_rvalid  = done && (owner == OWNER_D);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid  ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      owner <= OWNER_IF;
      rst_q <= 1'b1;
`ifdef MEM_ARB_RR_EN
      last  <= OWNER_IF;
`endif
    end else begin
      rst_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_en) begin
            owner <= d_gnt ? OWNER_D : OWNER_IF;
            cnt   <= CNT_INIT;
            state <= WAIT;
`ifdef MEM_ARB_RR_EN
            last  <= d_gnt ? OWNER_D : OWNER_IF;
`endif
          end
        end
        WAIT: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 3'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: randomized fetch/load/store traffic checked
// against a transaction-level model; a second LATENCY=1 instance checks back-to-back fetch.
`ifndef WORD
`define WORD 32
`endif

module tb_mem_arbiter;

  localparam int unsigned LAT = 2;
  localparam int unsigned AW  = `WORD;
  localparam int unsigned W   = `WORD;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [W-1:0]  if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [W-1:0]  d_wdata, d_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(LAT), .ADDR_W(AW)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // LATENCY=1 instance: fetch only, request held high continuously.
  logic          g1_req, g1_gnt, g1_rv, g1_dgnt, g1_drv, g1_men, g1_mwe, g1_busy;
  logic [AW-1:0] a1, g1_maddr;
  logic [W-1:0]  g1_rdata, g1_drdata, g1_mwdata, g1_mrdata;

  mem_arbiter #(.LATENCY(1), .ADDR_W(AW)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(g1_req), .if_addr(a1), .if_gnt(g1_gnt), .if_rvalid(g1_rv), .if_rdata(g1_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr('0), .d_wdata('0),
    .d_gnt(g1_dgnt), .d_rvalid(g1_drv), .d_rdata(g1_drdata),
    .mem_en(g1_men), .mem_we(g1_mwe), .mem_addr(g1_maddr), .mem_wdata(g1_mwdata),
    .mem_rdata(g1_mrdata), .busy(g1_busy)
  );

  function automatic logic [W-1:0] init_val(input logic [AW-1:0] a);
    if (a == AW'('h10)) return 32'h00500093;
    return a * 32'h9E3779B1 ^ 32'h5A5A1234;
  endfunction

  // Memory: reads return LAT cycles after mem_en; junk on all other cycles.
  logic [W-1:0] mem_store [logic [AW-1:0]];
  logic [W-1:0] rd_pipe [LAT];
  logic [W-1:0] mr1;
  always @(posedge clk) begin
    logic [W-1:0] v;
    v = $urandom;
    if (mem_en && !mem_we) v = mem_store.exists(mem_addr) ? mem_store[mem_addr] : init_val(mem_addr);
    if (mem_en && mem_we) mem_store[mem_addr] = mem_wdata;
    for (int i = LAT - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
    rd_pipe[0] = v;
    mr1 = g1_men ? init_val(g1_maddr) : $urandom;
  end
  assign mem_rdata = rd_pipe[LAT-1];
  assign g1_mrdata = mr1;

  // Reference model state
  typedef struct {
    logic        owner;
    logic        store;
    logic [W-1:0] data;
    int unsigned due;
  } rsp_t;
  rsp_t          q[$];
  logic [W-1:0]  ref_store [logic [AW-1:0]];
  int unsigned   cyc = 0, free_at = 0, g_cyc = 0;
  bit            g_valid = 0, chk_en = 0;
  bit            if_gnt_seen = 0, d_gnt_seen = 0, g1_gnt_seen = 0;
  bit            if_pend = 0, d_pend = 0;
`ifdef MEM_ARB_RR_EN
  logic          last_m = 1'b0;
`endif
  int            checks = 0, errors = 0;

  function automatic logic [W-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_store.exists(a) ? ref_store[a] : init_val(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor / scoreboard for the LATENCY=2 instance
  always @(negedge clk) begin
    bit   can, e_if, e_d, e_rv, f_own;
    rsp_t r;
    if_gnt_seen = (if_gnt === 1'b1);
    d_gnt_seen  = (d_gnt === 1'b1);
    if (chk_en) begin
      if (d_pend) chk("d_req_held", d_req, 1);
      if (if_pend) chk("if_req_held", if_req, 1);
      can = (cyc >= free_at) && !rst;
`ifdef MEM_ARB_RR_EN
      e_d = can && d_req && (!if_req || !last_m);
`else
      e_d = can && d_req;
`endif
      e_if = can && if_req && !e_d;
      chk("if_gnt", if_gnt, e_if);
      chk("d_gnt", d_gnt, e_d);
      chk("mem_en", mem_en, e_if || e_d);
      chk("busy", busy, g_valid && cyc > g_cyc && cyc <= g_cyc + LAT);
      if (e_d) begin
        chk("mem_addr_d", mem_addr, d_addr);
        chk("mem_we_d", mem_we, d_we);
        if (d_we) chk("mem_wdata", mem_wdata, d_wdata);
      end else if (e_if) begin
        chk("mem_addr_if", mem_addr, if_addr);
        chk("mem_we_if", mem_we, 0);
      end else begin
        chk("mem_we_idle", mem_we, 0);
      end
      e_rv  = 0;
      f_own = 0;
      if (!rst && q.size() > 0) begin
        e_rv  = (q[0].due == cyc);
        f_own = q[0].owner;
      end
      chk("if_rvalid", if_rvalid, e_rv && !f_own);
      chk("d_rvalid", d_rvalid, e_rv && f_own);
      if (e_rv) begin
        r = q.pop_front();
        if (!r.owner) chk("if_rdata", if_rdata, r.data);
        else if (!r.store) chk("d_rdata", d_rdata, r.data);
      end
      if (!(e_rv && !f_own)) chk("if_rdata_zero", if_rdata, 0);
      if (!(e_rv && f_own)) chk("d_rdata_zero", d_rdata, 0);
      if (e_if || e_d) begin
        r.owner = e_d;
        r.store = e_d && d_we;
        r.due   = cyc + LAT;
        if (e_d) begin
          r.data = d_we ? '0 : ref_rd(d_addr);
          if (d_we) ref_store[d_addr] = d_wdata;
        end else begin
          r.data = ref_rd(if_addr);
        end
        q.push_back(r);
        free_at = cyc + LAT + 1;
        g_cyc   = cyc;
        g_valid = 1;
`ifdef MEM_ARB_RR_EN
        last_m  = e_d;
`endif
      end
    end
    if (rst) begin
      q.delete();
      g_valid = 0;
      free_at = cyc + 2;
      chk_en  = 1;
`ifdef MEM_ARB_RR_EN
      last_m  = 1'b0;
`endif
    end
    if_pend = if_req && !if_gnt;
    d_pend  = d_req && !d_gnt;
    cyc++;
  end

  // Monitor for the LATENCY=1 instance
  bit          g1_prev = 0, g1_started = 0;
  logic [AW-1:0] a1_prev = '0;
  int          g1_cnt = 0;
  always @(negedge clk) begin
    g1_gnt_seen = (g1_gnt === 1'b1);
    if (chk_en) begin
      chk("l1_dgnt", g1_dgnt, 0);
      chk("l1_drvalid", g1_drv, 0);
      chk("l1_drdata", g1_drdata, 0);
      chk("l1_mem_we", g1_mwe, 0);
      chk("l1_mem_wdata", g1_mwdata, 0);
      if (rst) begin
        chk("l1_gnt_rst", g1_gnt, 0);
        chk("l1_rvalid_rst", g1_rv, 0);
      end else begin
        chk("l1_rvalid", g1_rv, g1_prev);
        chk("l1_busy", g1_busy, g1_prev);
        if (g1_prev) chk("l1_rdata", g1_rdata, init_val(a1_prev));
        if (g1_started) chk("l1_gnt_alt", g1_gnt, !g1_prev);
      end
    end
    if (rst) begin
      g1_prev    = 0;
      g1_started = 0;
    end else begin
      g1_prev = g1_gnt_seen;
      a1_prev = a1;
      if (g1_gnt_seen) begin
        g1_started = 1;
        g1_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (if_req && if_gnt_seen) if_req = 0;
    if (d_req && d_gnt_seen) d_req = 0;
    if (g1_gnt_seen) a1 = a1 + AW'(4);
  endtask

  task automatic issue_if(input logic [AW-1:0] a);
    if_req  = 1;
    if_addr = a;
  endtask

  task automatic issue_d(input logic we, input logic [AW-1:0] a, input logic [W-1:0] wd);
    d_req   = 1;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
  endtask

  function automatic logic [AW-1:0] raddr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 15)) << 2;
    return a;
  endfunction

  task automatic drain();
    int n = 0;
    while ((if_req || d_req || q.size() != 0) && n < 40) begin
      step();
      n++;
    end
    chk("drain_timeout", n >= 40, 0);
  endtask

  initial begin
    rst = 1; if_req = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    g1_req = 0; a1 = '0;
    repeat (3) step();
    rst = 0;
    g1_req = 1;

    step(); issue_if(AW'('h10)); drain();
    step(); issue_d(1, AW'('h40), 32'hDEADBEEF); drain();
    step(); issue_d(0, AW'('h40), '0); drain();
    step(); issue_if(AW'('h8)); issue_d(0, AW'('h40), '0); drain();

    // Sustained contention: both requesters re-request as soon as granted.
    for (int i = 0; i < 12; i++) begin
      step();
      if (!if_req) issue_if(raddr());
      if (!d_req) issue_d(1'($urandom_range(0, 1)), raddr(), $urandom);
    end
    d_req = d_req;
    for (int i = 0; i < 40 && d_req; i++) step();
    drain();

    // Reset during the first WAIT cycle of a fetch.
    step(); issue_if(AW'('h20));
    step(); rst = 1;
    step(); rst = 0;
    step(); issue_if(AW'('h24)); drain();

    for (int i = 0; i < 3000; i++) begin
      step();
      if (rst) rst = 0;
      else if ($urandom_range(0, 299) == 0) rst = 1;
      if (!if_req && $urandom_range(0, 2) == 0) issue_if(raddr());
      if (!d_req && $urandom_range(0, 2) == 0) issue_d(1'($urandom_range(0, 1)), raddr(), $urandom);
    end
    rst = 0;
    drain();
    chk("l1_grant_count", g1_cnt > 1000, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported memory between the fetch port (pc/instr) and the load/store port (ALUResult/writeData/readData/memWrite) of the cpu.
- One access outstanding at a time. Fixed memory read latency. Grant/valid handshake per requester.
- The cpu stalls on missing grants and valids.
- Sits between cpu and the unified memory model in the top level.

Parameters:
- LATENCY, 2, cycles from mem_en to valid mem_rdata (legal range 1..7).
- ADDR_W, `WORD, address width.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- if_req  input  1  fetch request; held until if_gnt
- if_addr  input  ADDR_W  fetch address (pc)
- if_gnt  output  1  fetch accepted this cycle
- if_rvalid  output  1  if_rdata valid this cycle
- if_rdata  output  `WORD  fetched instruction
- d_req  input  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  input  1  1 = store, 0 = load
- d_addr  input  ADDR_W  data address (ALUResult)
- d_wdata  input  `WORD  store data
- d_gnt  output  1  data request accepted this cycle
- d_rvalid  output  1  load data valid, or store complete
- d_rdata  output  `WORD  load data
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  `WORD  memory write data
- mem_rdata  input  `WORD  memory read data, valid LATENCY cycles after mem_en
- busy  output  1  access outstanding

Behaviour:
- FSM states: IDLE, WAIT. Registers: cnt (3 bits), owner (0 = fetch, 1 = data), last (owner of previous grant).
- IDLE with any request:
  - Select a winner; the winner's gnt is driven combinationally the same cycle.
  - mem_en = 1; mem_addr, mem_we and mem_wdata are muxed from the winner. mem_we = d_we only for a data winner; 0 for fetch.
  - Register owner; cnt <= LATENCY-1; go to WAIT.
- IDLE with no request: all strobes 0; mem_addr/mem_wdata are 0.
- WAIT:
  - cnt decrements each cycle.
  - When cnt == 0: the owner's rvalid = 1 and its rdata = mem_rdata; return to IDLE.
  - New requests are evaluated the cycle after that, in IDLE (no overlap).
- Latency: gnt to rvalid = LATENCY cycles. Throughput: one access per LATENCY+1 cycles.
- rdata outputs are 0 whenever the corresponding rvalid is 0.
- Store: d_rvalid pulses at the same point as for a load, as a completion ack. d_rdata is don't-care (drive mem_rdata).
- Arbitration, both requesting in IDLE: data wins (fixed priority; the data op belongs to the older instruction).
- The non-winning request stays pending and receives no gnt; the requester must hold it.
- Dropping req before gnt is illegal; the bench asserts this.
- Requests arriving during WAIT are ignored until IDLE.
- busy = (state == WAIT).
- Reset, including mid-WAIT:
  - state = IDLE, cnt = 0, owner = 0, last = 0.
  - All gnt, rvalid and mem_en are 0 in the cycle after rst is sampled.
  - An in-flight response is discarded: no rvalid is ever produced for it.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - Contention is resolved round-robin: the winner is the requester other than last. last updates on every grant.
  - After reset last = 0 (fetch), so the first contention grants data.
  - Guarantees no more than one consecutive loss per requester.
- Undefined: fixed data priority as above; the last register is not instantiated.

Decomposition:
- Shared package (mem_pkg):
  - arb_state_t enum {IDLE, WAIT}.
  - OWNER_IF / OWNER_D constants.
  - Reuses the existing `WORD define.
- Natural sub-module: arb_pick, a combinational two-way picker covering fixed priority and round-robin.
  - Inputs: if_req, d_req, last. Outputs: grant_if, grant_d.
- Everything else stays in mem_arbiter (FSM, counter, muxes).

Test Plan:
- LATENCY=2, only if_req with if_addr=0x10, mem returns 0x00500093 -> if_gnt in cycle 0, mem_en=1, mem_addr=0x10, mem_we=0; if_rvalid=1 with if_rdata=0x00500093 in cycle 2; busy=1 in cycles 1-2.
- d_req store d_addr=0x40, d_wdata=0xDEADBEEF -> d_gnt, mem_we=1, mem_wdata=0xDEADBEEF in cycle 0; d_rvalid in cycle 2; if_rvalid never asserts.
- if_req and d_req both asserted in the same cycle from IDLE:
  - Without the macro -> d_gnt first, if_gnt in cycle 3 (the first IDLE cycle).
  - With MEM_ARB_RR_EN and three back-to-back contentions -> grants alternate d, if, d.
- rst asserted in cycle 1 of a fetch WAIT -> no if_rvalid at cycle 2 or later; busy=0 and mem_en=0 the cycle after rst; a new if_req after rst is granted normally.
- LATENCY=1, continuous if_req -> if_gnt every 2nd cycle, if_rvalid exactly 1 cycle after each gnt.
- Requester drops d_req before d_gnt while fetch is WAIT -> assertion fires; no d_gnt is issued.
